// File: rtl/jedro1_alu_pkg.sv
// Shared constants for the jedro_1 core: datapath widths and ALU operation codes.
// The decoder imports the same ALU_OP_* codes, so change them here only.
package jedro_1_defines;

   localparam int DATA_WIDTH     = 32;
   localparam int ALU_OP_WIDTH   = 4;
   localparam int REG_ADDR_WIDTH = 5;

   // Codes are {funct7[5], funct3}
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'b0000;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'b0001;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 4'b0010;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 4'b0011;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'b0100;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'b0101;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'b0110;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'b0111;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'b1000;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'b1101;

   typedef enum logic [1:0] {
      SHIFT_SLL = 2'b00,
      SHIFT_SRL = 2'b01,
      SHIFT_SRA = 2'b10
   } shift_mode_e;

endpackage

// File: rtl/jedro1_alu_shifter.sv
// Combinational 32-bit barrel shifter for SLL/SRL/SRA.
// Only the 5-bit shift amount is seen here; upper operand-B bits are dropped by the caller.
module jedro1_alu_shifter
   import jedro_1_defines::*;
(
   input  logic [31:0]  opa,
   input  logic [4:0]   shamt,
   input  shift_mode_e  mode,
   output logic [31:0]  res
);

   always_comb begin
      res = '0;
      case (mode)
         SHIFT_SLL: res = opa << shamt;
         SHIFT_SRL: res = opa >> shamt;
         SHIFT_SRA: res = $unsigned($signed(opa) >>> shamt);
         default:   res = '0;
      endcase
   end

endmodule

// File: rtl/jedro1_alu.sv
// Registered RV32I integer ALU: one-cycle latency, result plus signed-overflow flag,
// with the destination address and writeback enable carried alongside the result.
module jedro1_alu
   import jedro_1_defines::*;
#(
   parameter int DATA_WIDTH     = jedro_1_defines::DATA_WIDTH,
   parameter int ALU_OP_WIDTH   = jedro_1_defines::ALU_OP_WIDTH,
   parameter int REG_ADDR_WIDTH = jedro_1_defines::REG_ADDR_WIDTH
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic [ALU_OP_WIDTH-1:0]   alu_op_sel_i,
   input  logic [DATA_WIDTH-1:0]     opa_i,
   input  logic [DATA_WIDTH-1:0]     opb_i,
   output logic [DATA_WIDTH-1:0]     res_o,
   output logic                      overflow_o,
   input  logic [REG_ADDR_WIDTH-1:0] reg_alu_dest_addr_i,
   output logic [REG_ADDR_WIDTH-1:0] reg_alu_dest_addr_o,
   input  logic                      alu_reg_wb_i,
   output logic                      alu_reg_wb_o
);

   logic [DATA_WIDTH-1:0] add_res;
   logic [DATA_WIDTH-1:0] sub_res;
   logic [DATA_WIDTH-1:0] shift_res;
   logic                  add_ovf;
   logic                  sub_ovf;
   logic                  slt;
   logic                  sltu;
   shift_mode_e           shift_mode;
   logic [DATA_WIDTH-1:0] res_next;
   logic                  ovf_next;

   assign add_res = opa_i + opb_i;
   assign sub_res = opa_i - opb_i;
   assign slt     = $signed(opa_i) < $signed(opb_i);
   assign sltu    = opa_i < opb_i;

   // Overflow: result sign disagrees with opa's sign when the operation could not legally flip it
   assign add_ovf = (opa_i[DATA_WIDTH-1] == opb_i[DATA_WIDTH-1]) &&
                    (add_res[DATA_WIDTH-1] != opa_i[DATA_WIDTH-1]);
   assign sub_ovf = (opa_i[DATA_WIDTH-1] != opb_i[DATA_WIDTH-1]) &&
                    (sub_res[DATA_WIDTH-1] != opa_i[DATA_WIDTH-1]);

   always_comb begin
      shift_mode = SHIFT_SRL;
      if (alu_op_sel_i == ALU_OP_SLL) begin
         shift_mode = SHIFT_SLL;
      end else if (alu_op_sel_i == ALU_OP_SRA) begin
         shift_mode = SHIFT_SRA;
      end
   end

   jedro1_alu_shifter u_shifter (
      .opa   (opa_i),
      .shamt (opb_i[4:0]),
      .mode  (shift_mode),
      .res   (shift_res)
   );

   always_comb begin
      res_next = '0;
      ovf_next = 1'b0;
      case (alu_op_sel_i)
         ALU_OP_ADD: begin
            res_next = add_res;
            ovf_next = add_ovf;
         end
         ALU_OP_SUB: begin
            res_next = sub_res;
            ovf_next = sub_ovf;
         end
         ALU_OP_SLT:  res_next = {{(DATA_WIDTH-1){1'b0}}, slt};
         ALU_OP_SLTU: res_next = {{(DATA_WIDTH-1){1'b0}}, sltu};
         ALU_OP_XOR:  res_next = opa_i ^ opb_i;
         ALU_OP_OR:   res_next = opa_i | opb_i;
         ALU_OP_AND:  res_next = opa_i & opb_i;
         ALU_OP_SLL,
         ALU_OP_SRL,
         ALU_OP_SRA:  res_next = shift_res;
         default: begin
            res_next = '0;
            ovf_next = 1'b0;
         end
      endcase
   end

   // Asynchronous reset also kills an in-flight writeback immediately
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         res_o               <= '0;
         overflow_o          <= 1'b0;
         reg_alu_dest_addr_o <= '0;
         alu_reg_wb_o        <= 1'b0;
      end else begin
         res_o               <= res_next;
         overflow_o          <= ovf_next;
         reg_alu_dest_addr_o <= reg_alu_dest_addr_i;
         alu_reg_wb_o        <= alu_reg_wb_i;
      end
   end

endmodule

// File: tb/tb_jedro1_alu.sv
// Directed-vector bench for jedro1_alu with hand-computed expectations.
module tb_jedro1_alu;
   import jedro_1_defines::*;

   logic        clk_i;
   logic        rstn_i;
   logic [3:0]  alu_op_sel_i;
   logic [31:0] opa_i;
   logic [31:0] opb_i;
   logic [31:0] res_o;
   logic        overflow_o;
   logic [4:0]  reg_alu_dest_addr_i;
   logic [4:0]  reg_alu_dest_addr_o;
   logic        alu_reg_wb_i;
   logic        alu_reg_wb_o;

   int errorCount = 0;
   int checkCount = 0;

   jedro1_alu dut (
      .clk_i               (clk_i),
      .rstn_i              (rstn_i),
      .alu_op_sel_i        (alu_op_sel_i),
      .opa_i               (opa_i),
      .opb_i               (opb_i),
      .res_o               (res_o),
      .overflow_o          (overflow_o),
      .reg_alu_dest_addr_i (reg_alu_dest_addr_i),
      .reg_alu_dest_addr_o (reg_alu_dest_addr_o),
      .alu_reg_wb_i        (alu_reg_wb_i),
      .alu_reg_wb_o        (alu_reg_wb_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive one operation, then sample one time unit after the capturing edge
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] dest, input logic wb);
      alu_op_sel_i        = op;
      opa_i               = a;
      opb_i               = b;
      reg_alu_dest_addr_i = dest;
      alu_reg_wb_i        = wb;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rstn_i              = 1'b0;
      alu_op_sel_i        = 4'($urandom);
      opa_i               = $urandom;
      opb_i               = $urandom;
      reg_alu_dest_addr_i = 5'($urandom);
      alu_reg_wb_i        = 1'b1;

      #2;
      checkOutput("reset_res",  res_o, 32'h0);
      checkOutput("reset_ovf",  32'(overflow_o), 32'h0);
      checkOutput("reset_dest", 32'(reg_alu_dest_addr_o), 32'h0);
      checkOutput("reset_wb",   32'(alu_reg_wb_o), 32'h0);
      #5;
      rstn_i = 1'b1;
      #1;
      checkOutput("post_release_wb", 32'(alu_reg_wb_o), 32'h0);

      applyStimulus(ALU_OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd5, 1'b1);
      checkOutput("add_ovf_res",  res_o, 32'h8000_0000);
      checkOutput("add_ovf_flag", 32'(overflow_o), 32'h1);
      checkOutput("add_ovf_dest", 32'(reg_alu_dest_addr_o), 32'd5);
      checkOutput("add_ovf_wb",   32'(alu_reg_wb_o), 32'h1);

      applyStimulus(ALU_OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd9, 1'b0);
      checkOutput("add_wrap_res",  res_o, 32'h0);
      checkOutput("add_wrap_flag", 32'(overflow_o), 32'h0);
      checkOutput("add_wrap_dest", 32'(reg_alu_dest_addr_o), 32'd9);
      checkOutput("add_wrap_wb",   32'(alu_reg_wb_o), 32'h0);

      applyStimulus(ALU_OP_SUB, 32'h8000_0000, 32'h0000_0001, 5'd6, 1'b1);
      checkOutput("sub_ovf_res",  res_o, 32'h7FFF_FFFF);
      checkOutput("sub_ovf_flag", 32'(overflow_o), 32'h1);

      applyStimulus(ALU_OP_SUB, 32'd5, 32'd7, 5'd7, 1'b1);
      checkOutput("sub_neg_res",  res_o, 32'hFFFF_FFFE);
      checkOutput("sub_neg_flag", 32'(overflow_o), 32'h0);

      applyStimulus(ALU_OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 5'd8, 1'b1);
      checkOutput("slt_res", res_o, 32'h1);
      applyStimulus(ALU_OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd8, 1'b1);
      checkOutput("sltu_res", res_o, 32'h0);
      applyStimulus(ALU_OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 5'd8, 1'b1);
      checkOutput("sltu_true_res", res_o, 32'h1);

      applyStimulus(ALU_OP_SLL, 32'h8000_0010, 32'h0000_0024, 5'd10, 1'b1);
      checkOutput("sll_res", res_o, 32'h0000_0100);
      checkOutput("sll_ovf", 32'(overflow_o), 32'h0);
      applyStimulus(ALU_OP_SRL, 32'h8000_0010, 32'h0000_0024, 5'd11, 1'b1);
      checkOutput("srl_res", res_o, 32'h0800_0001);
      applyStimulus(ALU_OP_SRA, 32'h8000_0010, 32'h0000_0024, 5'd12, 1'b1);
      checkOutput("sra_res", res_o, 32'hF800_0001);
      applyStimulus(ALU_OP_SRA, 32'h8000_0010, 32'hFFFF_FFE0, 5'd12, 1'b1);
      checkOutput("sra_zero_res", res_o, 32'h8000_0010);
      applyStimulus(ALU_OP_SLL, 32'h1234_5678, 32'h0000_001F, 5'd13, 1'b1);
      checkOutput("sll_31_res", res_o, 32'h0000_0000);

      applyStimulus(ALU_OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd1, 1'b1);
      checkOutput("xor_res",  res_o, 32'hFF00_FF00);
      checkOutput("xor_dest", 32'(reg_alu_dest_addr_o), 32'd1);
      applyStimulus(ALU_OP_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd2, 1'b1);
      checkOutput("or_res",  res_o, 32'hFFF0_FFF0);
      checkOutput("or_dest", 32'(reg_alu_dest_addr_o), 32'd2);
      applyStimulus(ALU_OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd3, 1'b1);
      checkOutput("and_res",  res_o, 32'h00F0_00F0);
      checkOutput("and_dest", 32'(reg_alu_dest_addr_o), 32'd3);

      applyStimulus(4'b1111, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd31, 1'b1);
      checkOutput("illegal_res",  res_o, 32'h0);
      checkOutput("illegal_ovf",  32'(overflow_o), 32'h0);
      checkOutput("illegal_wb",   32'(alu_reg_wb_o), 32'h1);
      checkOutput("illegal_dest", 32'(reg_alu_dest_addr_o), 32'd31);

      applyStimulus(4'b1001, 32'h8000_0000, 32'h0000_0001, 5'd4, 1'b1);
      checkOutput("illegal_sub_like_res", res_o, 32'h0);
      checkOutput("illegal_sub_like_ovf", 32'(overflow_o), 32'h0);

      // Mid-stream reset must drop the pending writeback without waiting for a clock
      applyStimulus(ALU_OP_ADD, 32'h0000_0003, 32'h0000_0004, 5'd14, 1'b1);
      checkOutput("pre_reset_res", res_o, 32'h0000_0007);
      #1;
      rstn_i = 1'b0;
      #1;
      checkOutput("midreset_wb",   32'(alu_reg_wb_o), 32'h0);
      checkOutput("midreset_res",  res_o, 32'h0);
      checkOutput("midreset_dest", 32'(reg_alu_dest_addr_o), 32'h0);
      rstn_i = 1'b1;
      applyStimulus(ALU_OP_SUB, 32'h0000_0010, 32'h0000_0001, 5'd15, 1'b1);
      checkOutput("after_reset_res",  res_o, 32'h0000_000F);
      checkOutput("after_reset_dest", 32'(reg_alu_dest_addr_o), 32'd15);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/jedro1_alu.md
# jedro1_alu

Registered integer ALU of the jedro_1 RV32I core, in the execute stage between the decoder/register-file stage and register-file writeback. It performs the RV32I register–register and register–immediate arithmetic, logic, compare and shift operations on two 32-bit operands. It delivers the result one clock later together with a signed-overflow flag. It also carries the destination register address and the writeback-enable flag through the same pipeline stage, so writeback stays aligned with its result.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width
- ALU_OP_WIDTH, 4, operation-select width
- REG_ADDR_WIDTH, 5, register address width

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rstn_i  in  1  reset; asynchronous, active-low
- alu_op_sel_i  in  ALU_OP_WIDTH  operation code, {funct7[5], funct3}
- opa_i  in  DATA_WIDTH  operand A (rs1 data)
- opb_i  in  DATA_WIDTH  operand B (rs2 data or sign-extended immediate, muxed upstream)
- res_o  out  DATA_WIDTH  registered result
- overflow_o  out  1  registered signed-overflow flag
- reg_alu_dest_addr_i  in  REG_ADDR_WIDTH  destination register address for this operation
- reg_alu_dest_addr_o  out  REG_ADDR_WIDTH  registered copy, aligned with res_o
- alu_reg_wb_i  in  1  this operation writes back to the register file
- alu_reg_wb_o  out  1  registered copy; drives the register-file write enable

## Operation
- Operation codes:
  - ADD 0000
  - SLL 0001
  - SLT 0010
  - SLTU 0011
  - XOR 0100
  - SRL 0101
  - OR 0110
  - AND 0111
  - SUB 1000
  - SRA 1101
- All other codes produce a result of 0 and an overflow of 0. They do not affect the pass-through of the address or writeback flag.
- ADD/SUB: modulo 2^32. Overflow = 1 when both operands have the same sign (ADD) or different signs (SUB) and the result sign differs from opa_i's sign.
- SLT: result 1 if $signed(opa) < $signed(opb), else 0. SLTU compares unsigned. The result is zero-extended in both cases.
- Shifts: the amount is opb_i[4:0]; opb_i[31:5] is ignored. SRA replicates opa_i[31]. A shift by 0 returns opa_i unchanged.
- Overflow is 0 for every operation other than ADD/SUB.
- Every code has one unique combinational result. The unit needs no operand-ready handshake; it computes every cycle.
- x0 suppression is not done here. The register file ignores writes to address 0.

## Timing
- Latency is exactly 1 cycle. Inputs sampled at edge N appear on res_o, overflow_o, reg_alu_dest_addr_o and alu_reg_wb_o after edge N, all four in the same cycle.
- Throughput is one operation per cycle with no stalls. Back-to-back operations with different codes each produce their own result on consecutive cycles.
- Reset: while rstn_i = 0, all outputs are 0 immediately (asynchronous). Outputs stay 0 until the first rising edge after release.
- Reset asserted mid-stream: the in-flight result is discarded and alu_reg_wb_o drops to 0 at once, so no spurious writeback occurs.
- The unit stores no internal state other than the four output registers.

## Structure
- Shared package jedro_1_defines holds:
  - DATA_WIDTH, ALU_OP_WIDTH and REG_ADDR_WIDTH constants
  - ALU_OP_* code constants, reused by the decoder
- An optional sub-module, jedro1_alu_shifter, holds the combinational SLL/SRL/SRA barrel shifter: opa, shamt[4:0], mode in; 32-bit result out.
- The rest of the unit is one combinational case on alu_op_sel_i plus the output register block.

## Test plan
- Reset: hold rstn_i = 0 with random inputs. Expect res_o = 0, overflow_o = 0, reg_alu_dest_addr_o = 0 and alu_reg_wb_o = 0, with no clock edge needed.
- ADD overflow: ADD with 0x7FFFFFFF + 0x00000001, dest 5, wb 1. The next cycle must show res_o = 0x80000000, overflow_o = 1, dest_o = 5 and wb_o = 1.
- SUB overflow: SUB with 0x80000000 − 1. Expect 0x7FFFFFFF with overflow 1. SUB with 5 − 7 must give 0xFFFFFFFE with overflow 0.
- Compare: opa = 0xFFFFFFFF, opb = 1. SLT must give 1 and SLTU must give 0.
- Shifts: opa = 0x80000010, opb = 0x00000024 (shamt 4). Expect:
  - SLL = 0x00000100
  - SRL = 0x08000001
  - SRA = 0xF8000001
- Pipeline and illegal code: apply XOR, OR, AND back to back with opa = 0xF0F0F0F0 and opb = 0x0FF00FF0. The outputs on consecutive cycles must be 0xFF00FF00, 0xFFF0FFF0 and 0x00F000F0. Then apply code 1111 with wb 1; expect res_o = 0, overflow_o = 0 and wb_o = 1.
